// File: rtl/kernel_pkg.sv
// Shared types and frame defaults for the 3x3 kernel datapath.
// Pure declarations: no timing or flow-control behaviour of its own.
package kernel_pkg;

  localparam int IMG_W  = 256;
  localparam int IMG_H  = 256;
  localparam int DATA_W = 17;
  localparam int OUT_W  = 8;

  localparam logic [1:0] MODE_BLUR    = 2'b00;
  localparam logic [1:0] MODE_SHARPEN = 2'b01;
  localparam logic [1:0] MODE_OUTLINE = 2'b10;
  localparam logic [1:0] MODE_EMBOSS  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_WAIT,
    ST_WRITE,
    ST_NEXT,
    ST_FINISH
  } seq_state_e;

endpackage

// File: rtl/pixel_clamp.sv
// Saturates a signed filter result into an unsigned pixel; purely combinational,
// zero latency, no flow control.
module pixel_clamp #(
  parameter int DATA_W = kernel_pkg::DATA_W,
  parameter int OUT_W  = kernel_pkg::OUT_W
) (
  input  logic [DATA_W-1:0] din,
  output logic [OUT_W-1:0]  dout
);

  logic neg;
  logic over;

  assign neg  = din[DATA_W-1];
  // Any magnitude bit above the pixel width means the value exceeds the pixel range.
  assign over = |din[DATA_W-2:OUT_W];

  always_comb begin
    if (neg) begin
      dout = '0;
    end else if (over) begin
      dout = '1;
    end else begin
      dout = din[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/kernel_frame_sequencer.sv
// Raster-walks a frame: border pixels cost 3 cycles, interior 3 + fetch latency + write stall.
// Holds the write until wr_ready; abort or a fetch timeout ends the frame via a done pulse.
module kernel_frame_sequencer
  import kernel_pkg::*;
#(
  parameter int IMG_W      = kernel_pkg::IMG_W,
  parameter int IMG_H      = kernel_pkg::IMG_H,
  parameter int DATA_W     = kernel_pkg::DATA_W,
  parameter int OUT_W      = kernel_pkg::OUT_W,
  parameter int TIMEOUT    = 64,
  parameter int BORDER_VAL = 0
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode_in,
  output logic [1:0]        mode_sel,
  output logic              win_req,
  output logic [7:0]        win_x,
  output logic [7:0]        win_y,
  input  logic              win_ready,
  input  logic [DATA_W-1:0] filt_result,
  output logic              wr_en,
  output logic [15:0]       wr_addr,
  output logic [OUT_W-1:0]  wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done,
  output logic              err_timeout
);

  localparam int              TW     = $clog2(TIMEOUT + 1);
  localparam logic [7:0]      X_LAST = 8'(IMG_W - 1);
  localparam logic [7:0]      Y_LAST = 8'(IMG_H - 1);
  localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT - 1);

  seq_state_e       state;
  seq_state_e       state_nxt;
  logic [7:0]       x_q;
  logic [7:0]       y_q;
  logic [TW-1:0]    tcnt_q;
  logic [OUT_W-1:0] clamp_dat;
  logic             border;
  logic             last_pix;
  logic             timeout_hit;

  pixel_clamp #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W)
  ) u_clamp (
    .din  (filt_result),
    .dout (clamp_dat)
  );

  assign border   = (x_q == '0) || (y_q == '0) || (x_q == X_LAST) || (y_q == Y_LAST);
  assign last_pix = (x_q == X_LAST) && (y_q == Y_LAST);
  // tcnt_q holds the number of cycles elapsed since the win_req cycle.
  assign timeout_hit = (state == ST_WAIT) && !win_ready && (tcnt_q == T_LAST);

  assign win_x   = x_q;
  assign win_y   = y_q;
  assign wr_addr = 16'(y_q) * 16'(IMG_W) + 16'(x_q);

  always_comb begin
    state_nxt = state;
    win_req   = 1'b0;
    wr_en     = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        win_req   = !border;
        state_nxt = border ? ST_WRITE : ST_WAIT;
      end
      ST_WAIT: begin
        if (win_ready) begin
          state_nxt = ST_WRITE;
        end else if (timeout_hit) begin
          state_nxt = ST_FINISH;
        end
      end
      ST_WRITE: begin
        wr_en = 1'b1;
        if (wr_ready) state_nxt = ST_NEXT;
      end
      ST_NEXT: begin
        state_nxt = last_pix ? ST_FINISH : ST_CHECK;
      end
      ST_FINISH: begin
        busy      = 1'b0;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Abort is ignored in IDLE (start wins) and in FINISH (done is already pulsing).
    if (abort && (state != ST_IDLE) && (state != ST_FINISH)) begin
      state_nxt = ST_FINISH;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      tcnt_q      <= '0;
      mode_sel    <= '0;
      wr_data     <= '0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_sel    <= mode_in;
            x_q         <= '0;
            y_q         <= '0;
            err_timeout <= 1'b0;
          end
        end
        ST_CHECK: begin
          tcnt_q <= TW'(1);
          if (border) wr_data <= OUT_W'(BORDER_VAL);
        end
        ST_WAIT: begin
          if (win_ready) begin
            wr_data <= clamp_dat;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
            if (timeout_hit) err_timeout <= 1'b1;
          end
        end
        ST_NEXT: begin
          if (x_q == X_LAST) begin
            x_q <= '0;
            y_q <= y_q + 8'd1;
          end else begin
            x_q <= x_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_frame_sequencer.sv
// Randomised bench for kernel_frame_sequencer on a 4x4 frame: a queue-based model predicts
// the raster write stream and window requests, with literal checks pinning key scenarios.
module tb_kernel_frame_sequencer;

  localparam int W   = 4;
  localparam int H   = 4;
  localparam int N   = W * H;
  localparam int DW  = 17;
  localparam int TMO = 64;

  logic          clk = 1'b0;
  logic          n_rst, start, abort, win_ready, wr_ready;
  logic [1:0]    mode_in, mode_sel;
  logic          win_req, wr_en, busy, done, err_timeout;
  logic [7:0]    win_x, win_y, wr_data;
  logic [DW-1:0] filt_result;
  logic [15:0]   wr_addr;

  kernel_frame_sequencer #(
    .IMG_W(W), .IMG_H(H), .DATA_W(DW), .OUT_W(8), .TIMEOUT(TMO), .BORDER_VAL(0)
  ) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort), .mode_in(mode_in),
    .mode_sel(mode_sel), .win_req(win_req), .win_x(win_x), .win_y(win_y),
    .win_ready(win_ready), .filt_result(filt_result), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ready(wr_ready), .busy(busy), .done(done),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Stimulus knobs
  int lat_cfg;      // -1: never answer, 0: random 1..4, >0: fixed latency
  bit rdy_rand;
  bit stray_en;
  int stall_addr;
  bit stall_done;
  int mode_req;
  int force_q[$];
  int resp_q[$];

  // Model state
  int exp_addr, busy_cnt, wr_cnt, mode_exp;
  int done_cnt = 0;
  bit outstanding, prev_busy, abort_seen, abort_prev;
  int wd_log[N];
  int en_cnt[N];

  task automatic chk(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit interior(int a);
    int x = a % W;
    int y = a / W;
    return (x > 0) && (x < W - 1) && (y > 0) && (y < H - 1);
  endfunction

  function automatic int clampf(int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  // Fetch-unit responder
  initial begin
    bit pend;
    int cnt;
    int val;
    pend = 0; cnt = 0; val = 0;
    win_ready = 1'b0;
    filt_result = '0;
    forever begin
      @(negedge clk);
      win_ready = 1'b0;
      if (!n_rst || !busy) pend = 0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          win_ready   = 1'b1;
          filt_result = DW'(val);
          resp_q.push_back(val);
          pend = 0;
        end
      end else if (stray_en && $urandom_range(0, 3) == 0) begin
        win_ready   = 1'b1;
        filt_result = DW'($urandom);
      end
      if (n_rst && win_req) begin
        pend = 1;
        cnt  = (lat_cfg < 0) ? (1 << 30) : ((lat_cfg == 0) ? int'($urandom_range(1, 4)) : lat_cfg);
        if (force_q.size() > 0) val = force_q.pop_front();
        else if ($urandom_range(0, 7) == 0) val = ($urandom_range(0, 1) != 0) ? 65535 : -65536;
        else val = int'($urandom_range(0, 1200)) - 600;
      end
    end
  end

  // Output-buffer ready driver
  initial begin
    int left;
    left = 0;
    wr_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (left > 0) begin
        wr_ready = 1'b0;
        left--;
      end else if (wr_en && int'(wr_addr) == stall_addr && !stall_done) begin
        wr_ready   = 1'b0;
        left       = 9;
        stall_done = 1;
      end else begin
        wr_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
    end
  end

  // Compare process
  initial begin
    int e;
    forever begin
      @(negedge clk);
      #2;
      if (!n_rst) begin
        prev_busy   = 0;
        abort_prev  = 0;
        outstanding = 0;
      end else begin
        if (busy && !prev_busy) begin
          exp_addr = 0; busy_cnt = 0; wr_cnt = 0;
          outstanding = 0; abort_seen = 0;
          mode_exp = mode_req;
          resp_q.delete();
          for (int i = 0; i < N; i++) begin
            wd_log[i] = -1;
            en_cnt[i] = 0;
          end
        end
        if (abort_prev) begin
          chk("abort_done", done, 1);
          chk("abort_quiet", {wr_en, win_req, busy}, 0);
        end
        abort_prev = abort && busy;
        if (abort_prev) abort_seen = 1;
        if (busy) begin
          busy_cnt++;
          chk("mode_sel", mode_sel, mode_exp);
        end
        if (win_req) begin
          chk("req_single", {outstanding, wr_en}, 0);
          chk("req_interior", interior(exp_addr), 1);
          chk("req_xy", int'(win_x) * 256 + int'(win_y), (exp_addr % W) * 256 + exp_addr / W);
          outstanding = 1;
        end else if (outstanding && busy) begin
          chk("hold_xy", int'(win_x) * 256 + int'(win_y), (exp_addr % W) * 256 + exp_addr / W);
          if (win_ready) outstanding = 0;
        end
        if (wr_en) begin
          chk("wr_addr", wr_addr, exp_addr);
          e = 0;
          if (interior(exp_addr)) begin
            if (resp_q.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL wr_resp: write to %0d with no window delivered (t=%0t)", wr_addr, $time);
              e = -1;
            end else begin
              e = clampf(resp_q[0]);
            end
          end
          chk("wr_data", wr_data, e);
          if (exp_addr < N) en_cnt[exp_addr]++;
          if (wr_ready) begin
            if (exp_addr < N) wd_log[exp_addr] = int'(wr_data);
            if (interior(exp_addr) && resp_q.size() > 0) void'(resp_q.pop_front());
            exp_addr++;
            wr_cnt++;
          end
        end
        if (done) begin
          done_cnt++;
          chk("done_busy", busy, 0);
          if (!abort_seen && !err_timeout) chk("frame_len", exp_addr, N);
        end
        prev_busy = busy;
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(int m);
    @(negedge clk);
    mode_in  = 2'(m);
    mode_req = m;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_done(string name, int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL %s: no done within %0d cycles", name, budget);
      if (busy) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic wait_req(string name);
    int k;
    k = 0;
    while (!win_req && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk(name, win_req, 1);
  endtask

  task automatic wait_wr(string name, int a);
    int k;
    k = 0;
    while (!(wr_en && int'(wr_addr) == a) && k < 80) begin
      @(negedge clk);
      k++;
    end
    chk(name, wr_en, 1);
  endtask

  initial begin
    int n;
    int d0;
    n_rst = 1'b0; start = 1'b0; abort = 1'b0; mode_in = '0; mode_req = 0;
    lat_cfg = 2; rdy_rand = 0; stray_en = 0; stall_addr = -1; stall_done = 1;
    #12;
    chk("reset_outs", {mode_sel, win_req, win_x, win_y, wr_en, wr_addr, wr_data, busy, done, err_timeout}, 0);
    @(negedge clk);
    n_rst = 1'b1;
    tick(2);

    // 4x4 frame, latency 2, constant result 100
    force_q = '{100, 100, 100, 100};
    do_start(0);
    wait_done("t1_done", 300);
    chk("t1_busy_cycles", busy_cnt, 56);
    chk("t1_writes", wr_cnt, 16);
    chk("t1_a0", wd_log[0], 0);
    chk("t1_a5", wd_log[5], 100);
    chk("t1_a6", wd_log[6], 100);
    chk("t1_a9", wd_log[9], 100);
    chk("t1_a10", wd_log[10], 100);
    chk("t1_a15", wd_log[15], 0);
    chk("t1_done_cnt", done_cnt, 1);

    // Clamp corners
    force_q = '{-5, 300, 255, 0};
    do_start(2);
    wait_done("t2_done", 300);
    chk("t2_a5", wd_log[5], 0);
    chk("t2_a6", wd_log[6], 255);
    chk("t2_a9", wd_log[9], 255);
    chk("t2_a10", wd_log[10], 0);

    // Mode latched at start; start while busy ignored
    do_start(1);
    tick(5);
    mode_in = 2'b11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t3_done", 300);
    chk("t3_writes", wr_cnt, 16);
    chk("t3_done_cnt", done_cnt, 3);
    do_start(3);
    chk("t3_mode_new", mode_sel, 3);
    wait_done("t3b_done", 300);

    // Write stall on address 6
    stall_addr = 6;
    stall_done = 0;
    do_start(0);
    wait_done("t4_done", 400);
    chk("t4_en_cycles_a6", en_cnt[6], 11);
    chk("t4_writes", wr_cnt, 16);
    stall_done = 1;

    // Window never arrives
    lat_cfg = -1;
    do_start(0);
    wait_req("t5_req");
    n = 0;
    while (!err_timeout && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t5_err_delay", n, TMO);
    chk("t5_done", done, 1);
    chk("t5_writes", wr_cnt, 5);
    @(negedge clk);
    if (busy) begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
    chk("t5_idle_sticky", {busy, err_timeout}, 1);
    lat_cfg = 2;
    do_start(0);
    chk("t5_err_clear", err_timeout, 0);
    wait_done("t5b_done", 300);

    // Abort while waiting for a window
    lat_cfg = 8;
    do_start(0);
    wait_req("t6_req");
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tick(12);
    chk("t6_writes", wr_cnt, 5);
    chk("t6_busy", busy, 0);
    lat_cfg = 2;

    // Abort coinciding with an accepted write
    do_start(0);
    wait_wr("t7_wr", 3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tick(4);
    chk("t7_writes", wr_cnt, 4);

    // start and abort together in IDLE
    @(negedge clk);
    mode_in = 2'b10; mode_req = 2; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    wait_done("t8_done", 300);
    chk("t8_writes", wr_cnt, 16);

    // Reset mid-write, then restart
    do_start(0);
    wait_wr("t9_wr", 2);
    d0 = done_cnt;
    n_rst = 1'b0;
    #2;
    chk("t9_reset_outs", {mode_sel, win_req, win_x, win_y, wr_en, wr_addr, wr_data, busy, done, err_timeout}, 0);
    tick(3);
    n_rst = 1'b1;
    tick(5);
    chk("t9_quiet", {busy, wr_en, win_req, done}, 0);
    chk("t9_no_done", done_cnt, d0);
    do_start(1);
    wait_done("t9b_done", 300);
    chk("t9b_writes", wr_cnt, 16);

    // Randomised frames
    rdy_rand = 1; stray_en = 1; lat_cfg = 0;
    for (int f = 0; f < 8; f++) begin
      do_start(int'($urandom_range(0, 3)));
      wait_done("rand_done", 1000);
      chk("rand_writes", wr_cnt, 16);
    end
    rdy_rand = 0; stray_en = 0;
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
